// File: rtl/stripe_cfg_sched_pkg.sv
// -----------------------------------------------------------------------------
// stripe_cfg_sched_pkg
// Shared definitions for the NodeStripe configuration scheduler:
//   - FSM state encoding (IDLE=0, LOAD=1, COMMIT=2, HOLD=3)
//   - descriptor field indices in stream order and the descriptor length
// No ports; imported by stripe_cfg_sched.
// -----------------------------------------------------------------------------
package stripe_cfg_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_COMMIT = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    // Descriptor words arrive in this order on the stream.
    localparam logic [2:0] F_INSTR    = 3'd0;
    localparam logic [2:0] F_TAG_A    = 3'd1;
    localparam logic [2:0] F_TAG_B    = 3'd2;
    localparam logic [2:0] F_STRIDE_A = 3'd3;
    localparam logic [2:0] F_STRIDE_B = 3'd4;
    localparam logic [2:0] F_ITER_LIM = 3'd5;
    localparam int         DESC_WORDS = 6;

endpackage

// File: rtl/stripe_cfg_sched_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin arbiter: picks the lowest requesting index
// at or after ptr, wrapping from N-1 back to 0.
// Ports:
//   req  in   N      request vector
//   ptr  in   PTR_W  index with highest priority this round
//   gnt  out  N      one-hot winner, 0 when no request
//   any  out  1      at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N     = 8,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic             any
);

    always_comb begin
        int  j;
        logic found;
        gnt   = '0;
        found = 1'b0;
        j     = 0;
        // Scan N positions starting at ptr; first hit wins.
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (!found && req[j]) begin
                gnt[j] = 1'b1;
                found  = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/stripe_cfg_sched.sv
// -----------------------------------------------------------------------------
// stripe_cfg_sched
// Schedules configuration of the NodeStripe array. A round-robin arbiter
// grants one requesting stripe; a 6-word descriptor is then streamed in and
// a one-hot write strobe is pulsed to the granted stripe.
// Ports:
//   clk, rst (async, active-low)
//   req[N]            per-stripe level request
//   grant[N]          one-hot current grant
//   desc_valid/ready  descriptor stream handshake, desc_data[DESC_WIDTH]
//   cfg_instr, cfg_tag_a, cfg_tag_b, cfg_stride_a, cfg_stride_b, cfg_iter_lim
//                     shared configuration bus
//   cfg_wr[N]         one-hot 1-cycle write strobe
//   busy              high whenever not IDLE
//   drop              1-cycle pulse when a descriptor is discarded
// -----------------------------------------------------------------------------
module stripe_cfg_sched
    import stripe_cfg_sched_pkg::*;
#(
    parameter int N_STRIPES   = 8,
    parameter int TAG_WIDTH   = 12,
    parameter int INSTR_WIDTH = 7,
    parameter int DESC_WIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_STRIPES-1:0]   req,
    output logic [N_STRIPES-1:0]   grant,
    input  logic                   desc_valid,
    input  logic [DESC_WIDTH-1:0]  desc_data,
    output logic                   desc_ready,
    output logic [INSTR_WIDTH-1:0] cfg_instr,
    output logic [TAG_WIDTH-1:0]   cfg_tag_a,
    output logic [TAG_WIDTH-1:0]   cfg_tag_b,
    output logic [TAG_WIDTH-1:0]   cfg_stride_a,
    output logic [TAG_WIDTH-1:0]   cfg_stride_b,
    output logic [TAG_WIDTH-1:0]   cfg_iter_lim,
    output logic [N_STRIPES-1:0]   cfg_wr,
    output logic                   busy,
    output logic                   drop
);

    localparam int PTR_W = (N_STRIPES > 1) ? $clog2(N_STRIPES) : 1;

    state_t                 r_state;
    logic [PTR_W-1:0]       r_rr_ptr;
    logic [2:0]             r_word_cnt;
    logic [N_STRIPES-1:0]   r_grant;
    logic                   r_desc_ready;
    logic [INSTR_WIDTH-1:0] r_instr;
    logic [TAG_WIDTH-1:0]   r_tag_a;
    logic [TAG_WIDTH-1:0]   r_tag_b;
    logic [TAG_WIDTH-1:0]   r_stride_a;
    logic [TAG_WIDTH-1:0]   r_stride_b;
    logic [TAG_WIDTH-1:0]   r_iter_lim;
    logic [N_STRIPES-1:0]   r_cfg_wr;
    logic                   r_busy;
    logic                   r_drop;

    logic [N_STRIPES-1:0]   w_arb_gnt;
    logic                   w_arb_any;
    logic [PTR_W-1:0]       w_gnt_idx;
    logic [PTR_W-1:0]       w_next_ptr;
    logic                   w_owner_req;
    logic                   w_beat;
    logic                   w_unused_desc;

    rr_arbiter #(
        .N     (N_STRIPES),
        .PTR_W (PTR_W)
    ) u_arb (
        .req (req),
        .ptr (r_rr_ptr),
        .gnt (w_arb_gnt),
        .any (w_arb_any)
    );

    // Encode the one-hot grant back to an index for the pointer update.
    always_comb begin
        w_gnt_idx = '0;
        for (int k = 0; k < N_STRIPES; k++) begin
            if (r_grant[k]) begin
                w_gnt_idx = PTR_W'(k);
            end
        end
    end

    assign w_next_ptr  = (w_gnt_idx == PTR_W'(N_STRIPES - 1)) ? '0 : w_gnt_idx + 1'b1;
    assign w_owner_req = |(req & r_grant);
    assign w_beat      = desc_valid && r_desc_ready;

    // Upper descriptor bits beyond each field width are intentionally ignored.
    assign w_unused_desc = &{1'b0, desc_data};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_rr_ptr     <= '0;
            r_word_cnt   <= '0;
            r_grant      <= '0;
            r_desc_ready <= 1'b0;
            r_instr      <= '0;
            r_tag_a      <= '0;
            r_tag_b      <= '0;
            r_stride_a   <= '0;
            r_stride_b   <= '0;
            r_iter_lim   <= '0;
            r_cfg_wr     <= '0;
            r_busy       <= 1'b0;
            r_drop       <= 1'b0;
        end else begin
            r_cfg_wr <= '0;
            r_drop   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_arb_any) begin
                        r_grant      <= w_arb_gnt;
                        r_desc_ready <= 1'b1;
                        r_busy       <= 1'b1;
                        r_state      <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    // Words are consumed even if the grant was withdrawn, so
                    // the stream stays aligned for the next descriptor.
                    if (w_beat) begin
                        case (r_word_cnt)
                            F_INSTR:    r_instr    <= desc_data[INSTR_WIDTH-1:0];
                            F_TAG_A:    r_tag_a    <= desc_data[TAG_WIDTH-1:0];
                            F_TAG_B:    r_tag_b    <= desc_data[TAG_WIDTH-1:0];
                            F_STRIDE_A: r_stride_a <= desc_data[TAG_WIDTH-1:0];
                            F_STRIDE_B: r_stride_b <= desc_data[TAG_WIDTH-1:0];
                            default:    r_iter_lim <= desc_data[TAG_WIDTH-1:0];
                        endcase
                        if (r_word_cnt == F_ITER_LIM) begin
                            r_word_cnt   <= '0;
                            r_desc_ready <= 1'b0;
                            r_state      <= ST_COMMIT;
                        end else begin
                            r_word_cnt <= r_word_cnt + 3'd1;
                        end
                    end
                end
                ST_COMMIT: begin
                    if (w_owner_req) begin
                        r_cfg_wr <= r_grant;
                    end else begin
                        r_drop <= 1'b1;
                    end
                    r_rr_ptr <= w_next_ptr;
                    r_state  <= ST_HOLD;
                end
                ST_HOLD: begin
                    // Keep the grant until the stripe lowers req, so a still
                    // asserted level request is not taken as a new one.
                    if (!w_owner_req) begin
                        r_grant <= '0;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign grant        = r_grant;
    assign desc_ready   = r_desc_ready;
    assign cfg_instr    = r_instr;
    assign cfg_tag_a    = r_tag_a;
    assign cfg_tag_b    = r_tag_b;
    assign cfg_stride_a = r_stride_a;
    assign cfg_stride_b = r_stride_b;
    assign cfg_iter_lim = r_iter_lim;
    assign cfg_wr       = r_cfg_wr;
    assign busy         = r_busy;
    assign drop         = r_drop;

endmodule

// File: tb/tb_stripe_cfg_sched.sv
// -----------------------------------------------------------------------------
// tb_stripe_cfg_sched
// Directed bench for stripe_cfg_sched: single grant, full round-robin sweep,
// pointer wrap, withdrawn request, stalled stream, reset mid-descriptor.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_stripe_cfg_sched;

    localparam int N  = 8;
    localparam int TW = 12;
    localparam int IW = 7;
    localparam int DW = 16;

    logic          clk;
    logic          rst;
    logic [N-1:0]  req;
    logic [N-1:0]  grant;
    logic          desc_valid;
    logic [DW-1:0] desc_data;
    logic          desc_ready;
    logic [IW-1:0] cfg_instr;
    logic [TW-1:0] cfg_tag_a;
    logic [TW-1:0] cfg_tag_b;
    logic [TW-1:0] cfg_stride_a;
    logic [TW-1:0] cfg_stride_b;
    logic [TW-1:0] cfg_iter_lim;
    logic [N-1:0]  cfg_wr;
    logic          busy;
    logic          drop;

    int n_vec = 0;
    int n_err = 0;
    logic [DW-1:0] w [6];

    stripe_cfg_sched #(
        .N_STRIPES   (N),
        .TAG_WIDTH   (TW),
        .INSTR_WIDTH (IW),
        .DESC_WIDTH  (DW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .grant        (grant),
        .desc_valid   (desc_valid),
        .desc_data    (desc_data),
        .desc_ready   (desc_ready),
        .cfg_instr    (cfg_instr),
        .cfg_tag_a    (cfg_tag_a),
        .cfg_tag_b    (cfg_tag_b),
        .cfg_stride_a (cfg_stride_a),
        .cfg_stride_b (cfg_stride_b),
        .cfg_iter_lim (cfg_iter_lim),
        .cfg_wr       (cfg_wr),
        .busy         (busy),
        .drop         (drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_w(input logic [DW-1:0] a, b, c, d, e, f);
        w[0] = a; w[1] = b; w[2] = c; w[3] = d; w[4] = e; w[5] = f;
    endtask

    // One word per cycle, starting and ending on a falling edge.
    task automatic send_words(input int first, input int cnt);
        for (int i = first; i < first + cnt; i++) begin
            desc_valid = 1'b1;
            desc_data  = w[i];
            @(posedge clk);
            @(negedge clk);
        end
        desc_valid = 1'b0;
        desc_data  = '0;
    endtask

    task automatic wait_grant(input string tag, input logic [N-1:0] exp);
        int k;
        k = 0;
        while (grant == '0 && k < 30) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(grant), 32'(exp));
    endtask

    task automatic chk_fields(input string tag);
        chk({tag, "_instr"},  32'(cfg_instr),    32'(w[0][IW-1:0]));
        chk({tag, "_tagA"},   32'(cfg_tag_a),    32'(w[1][TW-1:0]));
        chk({tag, "_tagB"},   32'(cfg_tag_b),    32'(w[2][TW-1:0]));
        chk({tag, "_strA"},   32'(cfg_stride_a), 32'(w[3][TW-1:0]));
        chk({tag, "_strB"},   32'(cfg_stride_b), 32'(w[4][TW-1:0]));
        chk({tag, "_iter"},   32'(cfg_iter_lim), 32'(w[5][TW-1:0]));
    endtask

    // Grant -> 6 beats -> strobe -> stripe lowers req -> back to IDLE.
    task automatic full_cycle(input string tag, input int idx);
        logic [N-1:0] oh;
        oh = '0;
        oh[idx] = 1'b1;
        wait_grant({tag, "_grant"}, oh);
        send_words(0, 6);
        @(negedge clk);
        chk({tag, "_wr"}, 32'(cfg_wr), 32'(oh));
        req[idx] = 1'b0;
        @(negedge clk);
        chk({tag, "_release"}, 32'(grant), 32'h0);
    endtask

    initial begin
        rst        = 1'b0;
        req        = '0;
        desc_valid = 1'b0;
        desc_data  = '0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_ready", 32'(desc_ready), 32'h0);
        chk("rst_cfg_wr", 32'(cfg_wr), 32'h0);
        chk("rst_drop", 32'(drop), 32'h0);
        chk("rst_instr", 32'(cfg_instr), 32'h0);
        chk("rst_iter", 32'(cfg_iter_lim), 32'h0);
        rst = 1'b1;

        // 1: single request, no stalls, 7-cycle grant-to-strobe
        req = 8'b0000_0100;
        @(negedge clk);
        chk("t1_grant", 32'(grant), 32'h04);
        chk("t1_busy", 32'(busy), 32'h1);
        chk("t1_ready", 32'(desc_ready), 32'h1);
        set_w(16'h0045, 16'h0010, 16'h0020, 16'h0001, 16'h0002, 16'h0040);
        send_words(0, 6);
        chk("t1_wr_early", 32'(cfg_wr), 32'h0);
        chk("t1_ready_off", 32'(desc_ready), 32'h0);
        @(negedge clk);
        chk("t1_wr", 32'(cfg_wr), 32'h04);
        chk("t1_instr", 32'(cfg_instr), 32'h45);
        chk("t1_tagA", 32'(cfg_tag_a), 32'h010);
        chk("t1_tagB", 32'(cfg_tag_b), 32'h020);
        chk("t1_strA", 32'(cfg_stride_a), 32'h1);
        chk("t1_strB", 32'(cfg_stride_b), 32'h2);
        chk("t1_iter", 32'(cfg_iter_lim), 32'h040);
        req = '0;
        @(negedge clk);
        chk("t1_wr_once", 32'(cfg_wr), 32'h0);
        chk("t1_idle_grant", 32'(grant), 32'h0);
        chk("t1_idle_busy", 32'(busy), 32'h0);
        chk("t1_hold_fields", 32'(cfg_instr), 32'h45);

        // 2: all stripes request from rr_ptr=0
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        req = 8'hFF;
        for (int s = 0; s < N; s++) begin
            full_cycle($sformatf("t2_s%0d", s), s);
        end
        req = 8'hFF;
        wait_grant("t2_wrap_grant", 8'h01);
        send_words(0, 6);
        @(negedge clk);
        chk("t2_wrap_wr", 32'(cfg_wr), 32'h01);
        req = '0;
        @(negedge clk);

        // 3: move rr_ptr to 5, then 5 and 0 request together
        req = 8'h10;
        full_cycle("t3_s4", 4);
        req = 8'b0010_0001;
        full_cycle("t3_s5", 5);
        full_cycle("t3_s0", 0);

        // 4: stripe 3 withdraws mid-descriptor; rr_ptr=1 here
        req = 8'b0100_1001;
        wait_grant("t4_grant", 8'h08);
        set_w(16'hFFC5, 16'hA123, 16'hB456, 16'hC789, 16'hDABC, 16'hEFFF);
        send_words(0, 2);
        req[3] = 1'b0;
        send_words(2, 4);
        chk("t4_consumed", 32'(desc_ready), 32'h0);
        chk("t4_no_drop_yet", 32'(drop), 32'h0);
        @(negedge clk);
        chk("t4_wr", 32'(cfg_wr), 32'h0);
        chk("t4_drop", 32'(drop), 32'h1);
        chk_fields("t4");
        @(negedge clk);
        chk("t4_drop_once", 32'(drop), 32'h0);
        chk("t4_release", 32'(grant), 32'h0);
        wait_grant("t4_next_grant", 8'h40);

        // 5: stripe 6 loads with valid pattern 1,0,0,1,0,0,...
        set_w(16'h0001, 16'h0ABC, 16'h0DEF, 16'h0FFF, 16'h0000, 16'h0800);
        for (int i = 0; i < 6; i++) begin
            send_words(i, 1);
            if (i < 5) begin
                desc_data = 16'hDEAD;
                repeat (2) @(negedge clk);
                desc_data = '0;
            end
            if (i == 0) begin
                chk("t5_instr_beat", 32'(cfg_instr), 32'h01);
                chk("t5_tagA_stalled", 32'(cfg_tag_a), 32'h123);
                chk("t5_ready_stall", 32'(desc_ready), 32'h1);
            end
        end
        @(negedge clk);
        chk("t5_wr", 32'(cfg_wr), 32'h40);
        chk_fields("t5");
        req[6] = 1'b0;
        @(negedge clk);
        chk("t5_release", 32'(grant), 32'h0);

        // 6: reset while stripe 0 is mid-descriptor (word_cnt=3)
        wait_grant("t6_grant", 8'h01);
        set_w(16'h0045, 16'h0010, 16'h0020, 16'h0001, 16'h0002, 16'h0040);
        send_words(0, 3);
        #2 rst = 1'b0;
        #1;
        chk("t6_rst_grant", 32'(grant), 32'h0);
        chk("t6_rst_ready", 32'(desc_ready), 32'h0);
        chk("t6_rst_busy", 32'(busy), 32'h0);
        chk("t6_rst_instr", 32'(cfg_instr), 32'h0);
        chk("t6_rst_tagA", 32'(cfg_tag_a), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        wait_grant("t6_regrant", 8'h01);
        set_w(16'h007F, 16'h0FFF, 16'h0111, 16'h0222, 16'h0333, 16'h0444);
        send_words(0, 6);
        @(negedge clk);
        chk("t6_wr", 32'(cfg_wr), 32'h01);
        chk_fields("t6");
        req = '0;
        @(negedge clk);
        chk("t6_idle", 32'(busy), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
